// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported 16-bit memory between CPU fetch and
// load/store ports; one transaction in flight, with a read-wait watchdog.
module mem_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ack,
    output logic [15:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        we;
        logic        is_data;
    } cmd_t;

    localparam bit            WDOG_EN  = (TIMEOUT != 0);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    cmd_t          cmd_q;
    logic          last_data_q;
    logic [CW-1:0] cnt_q;
    logic          grant, grant_data, expire, resolve;

    // Data wins unless fetch is also asking and data had the previous grant.
    assign grant      = (state_q == IDLE) && (if_req || d_req);
    assign grant_data = d_req && (!if_req || !last_data_q);

    // rvalid on the final wait cycle still counts as a hit.
    assign expire  = WDOG_EN && (state_q == WAIT) && !mem_rvalid && (cnt_q == LAST_CNT);
    assign resolve = (state_q == WAIT) && (mem_rvalid || expire);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (grant) state_d = ISSUE;
            ISSUE: if (mem_ready) state_d = cmd_q.we ? RESP : WAIT;
            WAIT:  if (resolve) state_d = RESP;
            RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            last_data_q <= 1'b0;
            cnt_q       <= '0;
            if_rdata    <= '0;
            d_rdata     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                cmd_q.addr    <= grant_data ? d_addr : if_addr;
                cmd_q.wdata   <= grant_data ? d_wdata : 16'h0000;
                cmd_q.we      <= grant_data & d_we;
                cmd_q.is_data <= grant_data;
                last_data_q   <= grant_data;
            end
            cnt_q <= (state_q == WAIT) ? cnt_q + CW'(1) : '0;
            if (resolve) begin
                if (cmd_q.is_data) d_rdata  <= mem_rvalid ? mem_rdata : 16'h0000;
                else               if_rdata <= mem_rvalid ? mem_rdata : 16'h0000;
            end
            if (expire) timeout_err <= 1'b1;
        end
    end

    assign busy      = (state_q != IDLE);
    assign mem_req   = (state_q == ISSUE);
    assign mem_we    = mem_req & cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign if_ack    = (state_q == RESP) && !cmd_q.is_data;
    assign d_ack     = (state_q == RESP) && cmd_q.is_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-timeline model (grant/accept/rvalid/ack cycle numbers)
// driving the memory side and predicting every output each cycle.
module tb_mem_arbiter;

    localparam int TIMEOUT = 4;

    logic        clk, rst;
    logic        if_req, if_ack, d_req, d_we, d_ack;
    logic        mem_req, mem_we, mem_ready, mem_rvalid, busy, timeout_err;
    logic [15:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    mem_arbiter #(.TIMEOUT(TIMEOUT), .CW(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: one transaction timeline (grant t0, accept ta, rvalid tv, ack tack).
    int          cyc, ta, tv, tack;
    bit          m_busy, m_we, m_win_d, m_abort, last_d, pend_f, pend_d, chk_en;
    logic [15:0] m_addr, m_wdata, m_rd_val;
    logic        e_busy, e_mem_req, e_mem_we, e_if_ack, e_d_ack, e_err;
    logic [15:0] e_if_rdata, e_d_rdata;
    int          mode;          // 0 directed/drop at ack, 1 directed/hold, 2 random
    int          force_rd, force_vd, force_data;
    int          n_chk, n_err;
    bit          glog[$];
    bit          dut_acks[$];
    bit          exp_ord[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_we = 0; m_win_d = 0; m_abort = 0; last_d = 0;
        pend_f = 0; pend_d = 0; cyc = -1; ta = 0; tv = 0; tack = 0;
        m_addr = '0; m_wdata = '0; m_rd_val = '0;
        e_busy = 0; e_mem_req = 0; e_mem_we = 0; e_if_ack = 0; e_d_ack = 0; e_err = 0;
        e_if_rdata = '0; e_d_rdata = '0;
    endtask

    task automatic new_d();
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 16'($urandom);
        d_wdata = 16'($urandom);
    endtask

    // Cycle start: predict outputs, drive the memory side, update requesters.
    task automatic cyc_begin();
        logic pf, pd, in_iss, in_wt;
        pf = e_if_ack;
        pd = e_d_ack;
        cyc++;
        if (m_busy && cyc > tack) m_busy = 0;
        if (m_busy && cyc == tack && !m_we) begin
            if (m_win_d) e_d_rdata = m_rd_val; else e_if_rdata = m_rd_val;
            if (m_abort) e_err = 1;
        end
        e_busy    = m_busy;
        e_mem_req = m_busy && cyc <= ta;
        e_mem_we  = e_mem_req && m_we;
        e_if_ack  = m_busy && cyc == tack && !m_win_d;
        e_d_ack   = m_busy && cyc == tack && m_win_d;

        in_iss = m_busy && cyc <= ta;
        in_wt  = m_busy && !m_we && cyc > ta && cyc < tack;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = (mode == 2) ? 16'($urandom) : 16'hDEAD;
        if (in_iss) mem_ready = (cyc == ta);
        else if (mode == 2) mem_ready = 1'($urandom_range(0, 1));
        if (in_wt) begin
            if (!m_abort && cyc == tv) begin
                mem_rvalid = 1'b1;
                mem_rdata  = m_rd_val;
            end
        end else if (m_busy && m_abort && cyc == tack) mem_rvalid = 1'b1;   // late data
        else if (mode == 2) mem_rvalid = 1'($urandom_range(0, 1));

        if (pf) begin
            pend_f = 0;
            if (mode == 2) begin
                if_req  = 1'($urandom_range(0, 1));
                if_addr = 16'($urandom);
            end else if_req = (mode == 1);
        end else if (mode == 2) begin
            if (pend_f) begin
                if (if_req && $urandom_range(0, 7) == 0) if_req = 1'b0;
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = 16'($urandom);
            end
        end
        if (pd) begin
            pend_d = 0;
            if (mode == 2) begin
                d_req = 1'($urandom_range(0, 1));
                new_d();
            end else d_req = (mode == 1);
        end else if (mode == 2) begin
            if (pend_d) begin
                if (d_req && $urandom_range(0, 7) == 0) d_req = 1'b0;
            end else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1;
                new_d();
            end
        end
    endtask

    // Cycle end: arbitration and timeline scheduling for a new grant.
    task automatic cyc_end();
        int rd, vd;
        bit wd;
        if (!m_busy && (if_req || d_req)) begin
            wd = d_req && (!if_req || !last_d);
            last_d  = wd;
            m_win_d = wd;
            m_we    = wd && d_we;
            m_addr  = wd ? d_addr : if_addr;
            m_wdata = wd ? d_wdata : 16'h0000;
            glog.push_back(wd);
            if (wd) pend_d = 1; else pend_f = 1;
            rd = (force_rd >= 0) ? force_rd : $urandom_range(0, 3);
            vd = (force_vd >= 0) ? force_vd : $urandom_range(0, 5);
            ta = cyc + 1 + rd;
            m_abort = 0;
            tv = -1;
            if (m_we) begin
                tack = ta + 1;
            end else if (vd < TIMEOUT) begin
                tv = ta + 1 + vd;
                tack = tv + 1;
                m_rd_val = (force_data >= 0) ? 16'(force_data) : 16'($urandom);
            end else begin
                m_abort = 1;
                tack = ta + 1 + TIMEOUT;
                m_rd_val = 16'h0000;
            end
            m_busy = 1;
        end
    endtask

    task automatic tick_begin();
        @(posedge clk);
        #1;
        cyc_begin();
    endtask

    task automatic step();
        tick_begin();
        cyc_end();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 16'(busy), 16'(e_busy));
            chk("mem_req", 16'(mem_req), 16'(e_mem_req));
            if (e_mem_req) begin
                chk("mem_we", 16'(mem_we), 16'(e_mem_we));
                chk("mem_addr", mem_addr, m_addr);
                if (e_mem_we) chk("mem_wdata", mem_wdata, m_wdata);
            end
            chk("if_ack", 16'(if_ack), 16'(e_if_ack));
            chk("d_ack", 16'(d_ack), 16'(e_d_ack));
            chk("if_rdata", if_rdata, e_if_rdata);
            chk("d_rdata", d_rdata, e_d_rdata);
            chk("timeout_err", 16'(timeout_err), 16'(e_err));
            if (if_ack) dut_acks.push_back(1'b0);
            if (d_ack)  dut_acks.push_back(1'b1);
        end
    end

    initial begin
        n_chk = 0; n_err = 0; chk_en = 0; mode = 0;
        force_rd = -1; force_vd = -1; force_data = -1;
        rst = 1'b1;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
        model_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_mem_req", 16'(mem_req), 16'h0);
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_acks", {14'b0, if_ack, d_ack}, 16'h0);
        chk("rst_if_rdata", if_rdata, 16'h0);
        chk("rst_d_rdata", d_rdata, 16'h0);
        chk("rst_timeout_err", 16'(timeout_err), 16'h0);
        repeat (2) @(posedge clk);

        // Fetch: accept in cycle 1, rvalid in cycle 3, ack in cycle 4
        force_rd = 0; force_vd = 1; force_data = 16'hA5A5;
        @(posedge clk); #1;
        rst = 1'b1;
        cyc_begin();
        if_req = 1'b1; if_addr = 16'h0010;
        cyc_end();
        chk_en = 1;
        step();
        chk("f_mem_req_c1", 16'(mem_req), 16'h1);
        chk("f_mem_addr_c1", mem_addr, 16'h0010);
        chk("f_mem_we_c1", 16'(mem_we), 16'h0);
        repeat (3) step();
        chk("f_if_ack_c4", 16'(if_ack), 16'h1);
        chk("f_if_rdata_c4", if_rdata, 16'hA5A5);
        chk("f_busy_c4", 16'(busy), 16'h1);
        step();
        chk("f_busy_c5", 16'(busy), 16'h0);
        chk("f_if_ack_c5", 16'(if_ack), 16'h0);

        // Store with mem_ready held off for 3 cycles
        force_rd = 3;
        tick_begin();
        d_req = 1; d_we = 1; d_addr = 16'h0200; d_wdata = 16'h1234;
        cyc_end();
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("s_mem_req", 16'(mem_req), 16'h1);
            chk("s_mem_addr", mem_addr, 16'h0200);
            chk("s_mem_wdata", mem_wdata, 16'h1234);
            chk("s_mem_we", 16'(mem_we), 16'h1);
        end
        step();
        chk("s_d_ack", 16'(d_ack), 16'h1);
        chk("s_mem_req_off", 16'(mem_req), 16'h0);
        step();
        chk("s_d_ack_once", 16'(d_ack), 16'h0);

        // Load returning BEEF
        force_rd = 1; force_vd = 0; force_data = 16'hBEEF;
        tick_begin();
        d_req = 1; d_we = 0; d_addr = 16'h0042;
        cyc_end();
        repeat (4) step();
        chk("l_d_ack", 16'(d_ack), 16'h1);
        chk("l_d_rdata", d_rdata, 16'hBEEF);
        step();

        // Load that never returns data: watchdog abort
        force_rd = 0; force_vd = 99;
        tick_begin();
        d_req = 1; d_we = 0; d_addr = 16'h0044;
        cyc_end();
        repeat (5) step();
        chk("t_d_ack_early", 16'(d_ack), 16'h0);
        chk("t_err_early", 16'(timeout_err), 16'h0);
        step();
        chk("t_d_ack", 16'(d_ack), 16'h1);
        chk("t_d_rdata", d_rdata, 16'h0000);
        chk("t_err", 16'(timeout_err), 16'h1);
        repeat (3) step();
        chk("t_err_sticky", 16'(timeout_err), 16'h1);
        chk("t_d_rdata_hold", d_rdata, 16'h0000);

        // Reset in the middle of a load's wait phase
        force_rd = 0; force_vd = 3; force_data = 16'h7777;
        tick_begin();
        d_req = 1; d_we = 0; d_addr = 16'h0050;
        cyc_end();
        repeat (3) step();
        #2;
        chk_en = 0;
        rst = 1'b0;
        #1;
        chk("r_busy", 16'(busy), 16'h0);
        chk("r_mem_req", 16'(mem_req), 16'h0);
        chk("r_d_ack", 16'(d_ack), 16'h0);
        chk("r_d_rdata", d_rdata, 16'h0);
        chk("r_err", 16'(timeout_err), 16'h0);
        model_reset();
        d_req = 0; if_req = 0; mem_ready = 0; mem_rvalid = 0;
        repeat (3) @(posedge clk);

        // Conflict right after reset, both requests held: D, F, D, F
        mode = 1; force_rd = 0; force_vd = 0; force_data = 16'h1111;
        glog.delete();
        dut_acks.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        cyc_begin();
        if_req = 1; if_addr = 16'h0300;
        d_req = 1; d_we = 1; d_addr = 16'h0400; d_wdata = 16'h5555;
        cyc_end();
        chk_en = 1;
        repeat (14) step();
        for (int i = 0; i < 4; i++) begin
            chk("ack_order", (dut_acks.size() > i) ? 16'(dut_acks[i]) : 16'hFFFF, 16'(exp_ord[i]));
            chk("grant_model", (glog.size() > i) ? 16'(glog[i]) : 16'hFFFF, 16'(exp_ord[i]));
        end

        // Random traffic with memory noise outside the active windows
        mode = 2; force_rd = -1; force_vd = -1; force_data = -1;
        repeat (3000) step();

        @(negedge clk);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
